// File: rtl/dmem_lsu_pkg.sv
// Shared constants and types for the data-memory load/store unit.
package dmem_lsu_pkg;

  // RISC-V load/store funct3 encodings (stores use only B/H/W)
  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  // IDLE accepts requests; LD2/LD_FIN finish a word-crossing load; ST2 writes
  // the upper word of a word-crossing store.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LD2    = 2'd1,
    LD_FIN = 2'd2,
    ST2    = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/dmem_lsu_align.sv
// Byte-lane alignment for dmem_lsu: request-side mask/data shifting and
// response-side extraction with sign/zero extension. Purely combinational.
module dmem_lsu_align
  import dmem_lsu_pkg::*;
(
  input  logic [1:0]  req_off,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic [7:0]  mask8,
  output logic [63:0] wide,
  output logic        split,
  input  logic [63:0] rd_window,
  input  logic [1:0]  rd_off,
  input  logic [2:0]  rd_funct3,
  output logic [31:0] rd_data
);

  logic [3:0]  base_mask;
  logic [31:0] rd_shifted;

  // Byte enables and lane-shifted store data across a two-word window
  always_comb begin
    case (req_funct3[1:0])
      2'd0:    base_mask = 4'b0001;
      2'd1:    base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
    mask8 = {4'b0000, base_mask} << req_off;
    wide  = {32'b0, req_wdata} << {req_off, 3'b000};
    split = |mask8[7:4];
  end

  // Pull the addressed bytes down to bit 0 and extend to 32 bits
  always_comb begin
    rd_shifted = 32'(rd_window >> {rd_off, 3'b000});
    case (rd_funct3)
      F3_B:    rd_data = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      F3_H:    rd_data = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      F3_W:    rd_data = rd_shifted;
      F3_BU:   rd_data = {24'b0, rd_shifted[7:0]};
      F3_HU:   rd_data = {16'b0, rd_shifted[15:0]};
      default: rd_data = 32'b0;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit in front of the byte-banked dmem. Aligned accesses take one
// memory cycle; word-crossing accesses are split into two word accesses.
//
// Handshake: a request is accepted on a cycle where i_req_valid && o_req_ready;
// i_req_* are sampled only then. o_req_ready is high only in IDLE (and never in
// reset). Every accepted request produces exactly one o_rsp_valid pulse, with
// o_rsp_err/o_rsp_rdata meaningful only while o_rsp_valid is high.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int DMEM_ADDR_WIDTH = 12
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_req_valid,
  output logic                       o_req_ready,
  input  logic                       i_req_write,
  input  logic [2:0]                 i_req_funct3,
  input  logic [31:0]                i_req_addr,
  input  logic [31:0]                i_req_wdata,
  output logic                       o_rsp_valid,
  output logic [31:0]                o_rsp_rdata,
  output logic                       o_rsp_err,
  output logic [DMEM_ADDR_WIDTH-1:0] o_mem_addr,
  output logic                       o_mem_read,
  output logic                       o_mem_write,
  output logic [3:0]                 o_mem_size,
  output logic [31:0]                o_mem_din,
  input  logic [31:0]                i_mem_dout
);

  localparam int WW = DMEM_ADDR_WIDTH - 2;
  localparam logic [WW-1:0] WORD_ONE = WW'(1);

  lsu_state_t  state;
  logic [WW-1:0] wa_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;
  logic        ld_q, err_q, rsp_q;
  logic [3:0]  hi_mask_q;
  logic [31:0] hi_din_q, lo_q;

  logic [7:0]  req_mask8;
  logic [63:0] req_wide;
  logic        req_split;
  logic [63:0] rd_window;
  logic [31:0] ext_data;
  logic        accept, f3_bad, range_bad, last_word, req_err;

  dmem_lsu_align u_align (
    .req_off    (i_req_addr[1:0]),
    .req_funct3 (i_req_funct3),
    .req_wdata  (i_req_wdata),
    .mask8      (req_mask8),
    .wide       (req_wide),
    .split      (req_split),
    .rd_window  (rd_window),
    .rd_off     (off_q),
    .rd_funct3  (f3_q),
    .rd_data    (ext_data)
  );

  assign o_req_ready = (state == IDLE) && i_rst_n;
  assign accept      = i_req_valid && o_req_ready;

  // Fault detection on the incoming request
  always_comb begin
    if (i_req_write) f3_bad = (i_req_funct3 > F3_W);
    else             f3_bad = (i_req_funct3 == 3'd3) || (i_req_funct3 == 3'd6) ||
                              (i_req_funct3 == 3'd7);
    range_bad = |i_req_addr[31:DMEM_ADDR_WIDTH];
    last_word = (&i_req_addr[DMEM_ADDR_WIDTH-1:2]) && req_split;
    req_err   = f3_bad || range_bad || last_word;
  end

  // Sequencer: captures the request at accept and walks split accesses
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      wa_q      <= '0;
      off_q     <= '0;
      f3_q      <= '0;
      ld_q      <= 1'b0;
      err_q     <= 1'b0;
      rsp_q     <= 1'b0;
      hi_mask_q <= '0;
      hi_din_q  <= '0;
      lo_q      <= '0;
    end else begin
      case (state)
        IDLE: begin
          rsp_q <= 1'b0;
          if (accept) begin
            wa_q      <= i_req_addr[DMEM_ADDR_WIDTH-1:2];
            off_q     <= i_req_addr[1:0];
            f3_q      <= i_req_funct3;
            ld_q      <= !i_req_write;
            err_q     <= req_err;
            hi_mask_q <= req_mask8[7:4];
            hi_din_q  <= req_wide[63:32];
            if (req_err || !req_split) rsp_q <= 1'b1;
            else if (i_req_write)      state <= ST2;
            else                       state <= LD2;
          end
        end
        LD2: begin
          lo_q  <= i_mem_dout;
          rsp_q <= 1'b0;
          state <= LD_FIN;
        end
        LD_FIN: begin
          rsp_q <= 1'b0;
          state <= IDLE;
        end
        ST2: begin
          rsp_q <= 1'b1;
          err_q <= 1'b0;
          ld_q  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory strobes: from the live request in IDLE, from captured state otherwise
  always_comb begin
    o_mem_addr  = '0;
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;
    o_mem_size  = 4'b0;
    o_mem_din   = 32'b0;
    case (state)
      IDLE: begin
        if (accept && !req_err) begin
          o_mem_addr  = {i_req_addr[DMEM_ADDR_WIDTH-1:2], 2'b00};
          o_mem_read  = !i_req_write;
          o_mem_write = i_req_write;
          o_mem_size  = req_mask8[3:0];
          if (i_req_write) o_mem_din = req_wide[31:0];
        end
      end
      LD2: begin
        o_mem_addr = {wa_q + WORD_ONE, 2'b00};
        o_mem_read = 1'b1;
        o_mem_size = hi_mask_q;
      end
      ST2: begin
        o_mem_addr  = {wa_q + WORD_ONE, 2'b00};
        o_mem_write = 1'b1;
        o_mem_size  = hi_mask_q;
        o_mem_din   = hi_din_q;
      end
      default: ;
    endcase
  end

  // Response: window is the upper word plus captured lower word for split loads
  assign rd_window   = (state == LD_FIN) ? {i_mem_dout, lo_q} : {32'b0, i_mem_dout};
  assign o_rsp_valid = rsp_q || (state == LD_FIN);
  assign o_rsp_err   = rsp_q && err_q;
  assign o_rsp_rdata = ((rsp_q && ld_q && !err_q) || (state == LD_FIN)) ? ext_data : 32'b0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a byte-banked memory model and a
// response scoreboard.
module tb_dmem_lsu;
  import dmem_lsu_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_req_valid, i_req_write;
  logic [2:0]  i_req_funct3;
  logic [31:0] i_req_addr, i_req_wdata;
  logic        o_req_ready, o_rsp_valid, o_rsp_err;
  logic [31:0] o_rsp_rdata;
  logic [11:0] o_mem_addr;
  logic        o_mem_read, o_mem_write;
  logic [3:0]  o_mem_size;
  logic [31:0] o_mem_din;
  logic [31:0] i_mem_dout;

  int errors = 0;
  int checks = 0;
  logic [32:0] exp_q[$];
  logic [32:0] mon_e;
  logic [31:0] mem [1024];
  logic [31:0] b2b [3];

  dmem_lsu #(.DMEM_ADDR_WIDTH(12)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_write(i_req_write), .i_req_funct3(i_req_funct3),
    .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
    .o_mem_addr(o_mem_addr), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_mem_size(o_mem_size), .o_mem_din(o_mem_din), .i_mem_dout(i_mem_dout)
  );

  // clock / reset-time memory init
  always #5 i_clk = ~i_clk;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'b0;
    i_mem_dout = 32'b0;
  end

  // byte-banked memory model: registered read data, held when no read
  always @(posedge i_clk) begin
    if (o_mem_write) begin
      for (int k = 0; k < 4; k++)
        if (o_mem_size[k]) mem[o_mem_addr[11:2]][8*k +: 8] <= o_mem_din[8*k +: 8];
    end
    if (o_mem_read) i_mem_dout <= mem[o_mem_addr[11:2]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // scoreboard monitor: every response pulse must match the head of exp_q
  always @(negedge i_clk) begin
    check("rw_excl", 32'(o_mem_read & o_mem_write), 32'd0);
    if (o_rsp_valid) begin
      if (exp_q.size() == 0) check("rsp_unexp", 32'(o_rsp_valid), 32'd0);
      else begin
        mon_e = exp_q.pop_front();
        check("rsp_data", o_rsp_rdata, mon_e[31:0]);
        check("rsp_err", 32'(o_rsp_err), 32'(mon_e[32]));
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic drive_req(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd);
    i_req_valid = 1'b1; i_req_write = wr; i_req_funct3 = f3;
    i_req_addr = a; i_req_wdata = wd;
  endtask

  task automatic drive_idle();
    i_req_valid  = 1'b0;
    i_req_write  = 1'($urandom_range(0, 1));
    i_req_funct3 = 3'($urandom_range(0, 7));
    i_req_addr   = $urandom;
    i_req_wdata  = $urandom;
  endtask

  // one non-split (or faulting) access: strobes on accept, response one cycle later
  task automatic single(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] e_addr, input logic e_rd, input logic e_wr,
                        input logic [3:0] e_size, input logic [31:0] e_din,
                        input logic [31:0] e_data, input logic e_err);
    exp_q.push_back({e_err, e_data});
    drive_req(wr, f3, a, wd);
    @(negedge i_clk);
    check({tag, "_ready"}, 32'(o_req_ready), 32'd1);
    check({tag, "_rd"},    32'(o_mem_read), 32'(e_rd));
    check({tag, "_wr"},    32'(o_mem_write), 32'(e_wr));
    check({tag, "_size"},  32'(o_mem_size), 32'(e_size));
    check({tag, "_addr"},  32'(o_mem_addr), e_addr);
    check({tag, "_din"},   o_mem_din, e_din);
    step();
    drive_idle();
    @(negedge i_clk);
    check({tag, "_rspv"},  32'(o_rsp_valid), 32'd1);
    step();
  endtask

  // word-crossing load: two reads, ready low two cycles, response in the second
  task automatic split_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] e_addr, input logic [3:0] e_sa,
                            input logic [3:0] e_sb, input logic [31:0] e_data);
    exp_q.push_back({1'b0, e_data});
    drive_req(1'b0, f3, a, 32'b0);
    @(negedge i_clk);
    check({tag, "_a_rd"},   32'(o_mem_read), 32'd1);
    check({tag, "_a_addr"}, 32'(o_mem_addr), e_addr);
    check({tag, "_a_size"}, 32'(o_mem_size), 32'(e_sa));
    step();
    drive_idle();
    @(negedge i_clk);
    check({tag, "_b_ready"}, 32'(o_req_ready), 32'd0);
    check({tag, "_b_rd"},    32'(o_mem_read), 32'd1);
    check({tag, "_b_addr"},  32'(o_mem_addr), e_addr + 32'd4);
    check({tag, "_b_size"},  32'(o_mem_size), 32'(e_sb));
    check({tag, "_b_rspv"},  32'(o_rsp_valid), 32'd0);
    step();
    @(negedge i_clk);
    check({tag, "_fin_ready"}, 32'(o_req_ready), 32'd0);
    check({tag, "_fin_rspv"},  32'(o_rsp_valid), 32'd1);
    check({tag, "_fin_rd"},    32'(o_mem_read), 32'd0);
    step();
    @(negedge i_clk);
    check({tag, "_post_ready"}, 32'(o_req_ready), 32'd1);
    check({tag, "_post_rspv"},  32'(o_rsp_valid), 32'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    b2b[0] = 32'h0BAD_F00D; b2b[1] = 32'h1234_5678; b2b[2] = 32'hFEDC_BA98;
    i_rst_n = 1'b0;
    i_req_valid = 1'b1; i_req_write = 1'b1; i_req_funct3 = F3_W;
    i_req_addr = 32'h10; i_req_wdata = 32'h5555_AAAA;

    // reset state, with a request already presented
    @(negedge i_clk);
    check("rst_ready", 32'(o_req_ready), 32'd0);
    check("rst_rspv",  32'(o_rsp_valid), 32'd0);
    check("rst_err",   32'(o_rsp_err), 32'd0);
    check("rst_rdata", o_rsp_rdata, 32'd0);
    check("rst_wr",    32'(o_mem_write), 32'd0);
    check("rst_rd",    32'(o_mem_read), 32'd0);
    check("rst_size",  32'(o_mem_size), 32'd0);
    step();
    drive_idle();
    step();
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("rel_ready", 32'(o_req_ready), 32'd1);
    step();

    // aligned word store and load
    single("sw10", 1, F3_W, 32'h010, 32'hDEAD_BEEF, 32'h010, 0, 1, 4'hF, 32'hDEAD_BEEF, 32'h0, 0);
    single("lw10", 0, F3_W, 32'h010, 32'h0,         32'h010, 1, 0, 4'hF, 32'h0, 32'hDEAD_BEEF, 0);

    // byte store to lane 3 (upper wdata bits must be ignored) and byte/half loads
    single("sb13",  1, F3_B,  32'h013, 32'h1234_5680, 32'h010, 0, 1, 4'b1000, 32'h8000_0000, 32'h0, 0);
    single("lb13",  0, F3_B,  32'h013, 32'h0, 32'h010, 1, 0, 4'b1000, 32'h0, 32'hFFFF_FF80, 0);
    single("lbu13", 0, F3_BU, 32'h013, 32'h0, 32'h010, 1, 0, 4'b1000, 32'h0, 32'h0000_0080, 0);
    single("lh12",  0, F3_H,  32'h012, 32'h0, 32'h010, 1, 0, 4'b1100, 32'h0, 32'hFFFF_80AD, 0);
    single("lhu10", 0, F3_HU, 32'h010, 32'h0, 32'h010, 1, 0, 4'b0011, 32'h0, 32'h0000_BEEF, 0);

    // misaligned word store: two writes on consecutive cycles
    exp_q.push_back({1'b0, 32'h0});
    drive_req(1'b1, F3_W, 32'h022, 32'h1122_3344);
    @(negedge i_clk);
    check("msw_a_wr",   32'(o_mem_write), 32'd1);
    check("msw_a_addr", 32'(o_mem_addr), 32'h020);
    check("msw_a_size", 32'(o_mem_size), 32'b1100);
    check("msw_a_din",  o_mem_din, 32'h3344_0000);
    step();
    drive_idle();
    @(negedge i_clk);
    check("msw_b_ready", 32'(o_req_ready), 32'd0);
    check("msw_b_wr",    32'(o_mem_write), 32'd1);
    check("msw_b_addr",  32'(o_mem_addr), 32'h024);
    check("msw_b_size",  32'(o_mem_size), 32'b0011);
    check("msw_b_din",   o_mem_din, 32'h0000_1122);
    check("msw_b_rspv",  32'(o_rsp_valid), 32'd0);
    step();
    @(negedge i_clk);
    check("msw_rspv",  32'(o_rsp_valid), 32'd1);
    check("msw_ready", 32'(o_req_ready), 32'd1);
    step();

    // misaligned loads across the same word boundary
    split_load("mlw22", F3_W, 32'h022, 32'h020, 4'b1100, 4'b0011, 32'h1122_3344);
    split_load("mlh23", F3_H, 32'h023, 32'h020, 4'b1000, 4'b0001, 32'h0000_2233);

    // faults: no strobe, err response with zero data
    single("e_range", 0, F3_H,  32'h1000, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1);
    single("e_last",  0, F3_W,  32'h0FFE, 32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1);
    single("e_ldf3",  0, 3'd3,  32'h010,  32'h0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1);
    single("e_stf3",  1, 3'd4,  32'h010,  32'hFFFF_FFFF, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0, 1);
    // last word itself is legal when aligned; faulting store left word 4 alone
    single("lw_top",  0, F3_W,  32'h0FFC, 32'h0, 32'hFFC, 1, 0, 4'hF, 32'h0, 32'h0, 0);
    single("lw10b",   0, F3_W,  32'h010,  32'h0, 32'h010, 1, 0, 4'hF, 32'h0, 32'h80AD_BEEF, 0);

    // back-to-back loads
    for (int i = 0; i < 3; i++)
      single("sw_b2b", 1, F3_W, 32'(i*4), b2b[i], 32'(i*4), 0, 1, 4'hF, b2b[i], 32'h0, 0);
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, b2b[i]});
    for (int i = 0; i < 3; i++) begin
      drive_req(1'b0, F3_W, 32'(i*4), 32'h0);
      @(negedge i_clk);
      check("b2b_ready", 32'(o_req_ready), 32'd1);
      check("b2b_addr",  32'(o_mem_addr), 32'(i*4));
      check("b2b_rspv",  32'(o_rsp_valid), 32'(i > 0));
      step();
    end
    drive_idle();
    @(negedge i_clk);
    check("b2b_last_rspv", 32'(o_rsp_valid), 32'd1);
    step();
    @(negedge i_clk);
    check("b2b_done_rspv", 32'(o_rsp_valid), 32'd0);
    step();

    // reset in the middle of a split store drops the second write
    drive_req(1'b1, F3_W, 32'h032, 32'hCAFE_F00D);
    @(negedge i_clk);
    check("rst_st_a_din", o_mem_din, 32'hF00D_0000);
    step();
    drive_idle();
    @(negedge i_clk);
    check("rst_st_b_wr",   32'(o_mem_write), 32'd1);
    check("rst_st_b_addr", 32'(o_mem_addr), 32'h034);
    i_rst_n = 1'b0;
    #1;
    check("rst_st_wr_drop", 32'(o_mem_write), 32'd0);
    check("rst_st_rspv",    32'(o_rsp_valid), 32'd0);
    check("rst_st_ready",   32'(o_req_ready), 32'd0);
    step();
    step();
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("rst_st_rel_ready", 32'(o_req_ready), 32'd1);
    check("rst_st_rel_rspv",  32'(o_rsp_valid), 32'd0);
    step();
    single("lw34", 0, F3_W, 32'h034, 32'h0, 32'h034, 1, 0, 4'hF, 32'h0, 32'h0, 0);
    single("lw30", 0, F3_W, 32'h030, 32'h0, 32'h030, 1, 0, 4'hF, 32'h0, 32'hF00D_0000, 0);

    step();
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Load/store unit sitting directly upstream of the byte-banked data memory: converts core load/store requests into bank byte-enables, lane-shifted write data and word addresses.
- Post-processes the memory's registered read data: byte/half extraction, sign/zero extension.
- Splits word-crossing (misaligned) accesses into two word accesses with a small FSM.
- Flags out-of-range addresses and illegal funct3.

Parameters:
- DMEM_ADDR_WIDTH, 12, byte-address width of dmem; valid byte addresses 0 .. 2^DMEM_ADDR_WIDTH-1.

Ports:
- i_clk, input, 1, clock.
- i_rst_n, input, 1, asynchronous active-low reset.
- i_req_valid, input, 1, core request valid.
- o_req_ready, output, 1, request accepted when valid&&ready.
- i_req_write, input, 1, 1=store, 0=load.
- i_req_funct3, input, 3, RISC-V funct3 (LB0 LH1 LW2 LBU4 LHU5; SB0 SH1 SW2).
- i_req_addr, input, 32, byte address.
- i_req_wdata, input, 32, store data, right-aligned.
- o_rsp_valid, output, 1, one-cycle response pulse.
- o_rsp_rdata, output, 32, extended load data; 0 for stores/errors.
- o_rsp_err, output, 1, access fault, qualified by o_rsp_valid.
- o_mem_addr, output, DMEM_ADDR_WIDTH, byte address to dmem; low 2 bits always 0.
- o_mem_read, output, 1, dmem read strobe.
- o_mem_write, output, 1, dmem write strobe.
- o_mem_size, output, 4, per-bank byte enables, bit k = bank k = data bits 8k+7:8k.
- o_mem_din, output, 32, lane-aligned write data.
- i_mem_dout, input, 32, dmem read data. Valid the cycle after o_mem_read; held while read is low.

Behaviour:
- Reset (async, i_rst_n=0):
  - State returns to IDLE; o_rsp_valid=0, o_rsp_err=0, o_rsp_rdata=0.
  - o_mem_read=0, o_mem_write=0, o_mem_size=0.
  - o_req_ready=0 while in reset, 1 after release.
  - Any in-flight second half of a split store is dropped.
- Size n = 1/2/4 bytes from funct3[1:0]; off = addr[1:0].
- mask8 = ((1<<n)-1) << off. Word A gets mask8[3:0]; word A+1 gets mask8[7:4].
- wide = {32'b0, wdata} << (8*off). Word A gets wide[31:0]; word A+1 gets wide[63:32].
- Split access when mask8[7:4] != 0.
- Error conditions (no memory strobe is raised on error):
  - Load funct3 in {3,6,7}, or store funct3 > 2.
  - addr[31:DMEM_ADDR_WIDTH] != 0.
  - Split access whose word A is the last word.
- FSM states: IDLE, LD2, LD_FIN, ST2. o_req_ready=1 only in IDLE. Memory outputs are combinational from the request in IDLE and from captured registers in the other states.
- IDLE, accept, no split:
  - Issue read or write of word A this cycle.
  - Next cycle: o_rsp_valid=1 (latency 1), state stays IDLE, so back-to-back requests are allowed.
- IDLE, accept, error: next cycle o_rsp_valid=1, o_rsp_err=1, rdata=0.
- IDLE, accept, split load: read A this cycle → LD2.
- LD2: capture i_mem_dout as lo; read A+4 → LD_FIN.
- LD_FIN:
  - rdata = extend(({i_mem_dout, lo} >> 8*off)[8n-1:0]).
  - o_rsp_valid=1 the same cycle (combinational from registered state) → IDLE. Split load latency is 2.
- IDLE, accept, split store: write A with mask8[3:0] → ST2.
- ST2: write A+4 with mask8[7:4] and wide[63:32]; o_rsp_valid next cycle → IDLE.
- Non-split load rdata = extend((i_mem_dout >> 8*off_q)[8n-1:0]), using the registered off/funct3.
- Extension: sign-extend for LB/LH, zero-extend for LBU/LHU/LW.
- o_mem_read and o_mem_write are never both 1. All unused outputs are driven to 0 (no X).
- i_req_* are sampled only at accept; later changes are ignored.

Decomposition:
- Package dmem_lsu_pkg:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU).
  - State enum lsu_state_t {IDLE, LD2, LD_FIN, ST2}.
- Sub-module dmem_lsu_align (combinational):
  - Computes mask8, wide and the split flag from addr/funct3/wdata.
  - Performs extract/extend from a 64-bit window.
- The FSM and registers live in the top.

Test Plan:
1. SW 0xDEADBEEF @0x010, then LW @0x010 → mem_size=4'b1111 on write; the load's rsp one cycle after accept, rdata=0xDEADBEEF, err=0.
2. SB 0x80 @0x013, then LB/LBU @0x013 → mem_size=4'b1000, din[31:24]=0x80; LB rdata=0xFFFFFF80, LBU rdata=0x00000080.
3. Misaligned SW 0x11223344 @0x022 → cycle0 addr 0x020 size 4'b1100 din 0x33440000; cycle1 addr 0x024 size 4'b0011 din 0x00001122. Then LW @0x022 → ready low 2 cycles, rdata=0x11223344 at LD_FIN.
4. LH @0x1000 (DMEM_ADDR_WIDTH=12), LW @0xFFE, funct3=3 load → each: no mem strobe, rsp_valid with err=1, rdata=0.
5. Back-to-back LW @0x0, 0x4, 0x8 on consecutive cycles → ready held 1, three rsp pulses in consecutive cycles with matching data.
6. Assert i_rst_n=0 during ST2 → mem_write drops immediately, rsp_valid=0; word A+4 unchanged; ready=1 after release.
